// File: rtl/tlp_tx_scheduler_if.sv
// 64-bit PCIe transmit beat stream between the TLP scheduler (master) and the
// endpoint TX port (slave).
interface tlp_tx_scheduler_if;
  logic [63:0] TxData;
  logic        TxSOF;
  logic        TxEOF;
  logic        TxRem;
  logic        TxValid;
  logic        TxReady;

  modport master (
    output TxData,
    output TxSOF,
    output TxEOF,
    output TxRem,
    output TxValid,
    input  TxReady
  );

  modport slave (
    input  TxData,
    input  TxSOF,
    input  TxEOF,
    input  TxRem,
    input  TxValid,
    output TxReady
  );
endinterface

// File: rtl/tlp_tx_scheduler.sv
// Drains the acquisition header/data FIFOs into posted Memory-Write TLPs on the
// PCIe core's 64-bit TX port, and flags completion of each ping-pong DMA buffer.
module tlp_tx_scheduler #(
  parameter int          WORDS_PER_TLP = 16,
  parameter logic [15:0] REQUESTER_ID  = 16'h0100
) (
  input  logic               Clock,
  input  logic               rst_n,
  input  logic               Enable,
  input  logic [31:0]        BufferBase0,
  input  logic [31:0]        BufferBase1,
  input  logic [15:0]        BufferLengthTLPs,
  input  logic               HeaderEmpty,
  input  logic [39:0]        HeaderQ,
  output logic               HeaderRead,
  input  logic [63:0]        DataQ,
  input  logic [9:0]         DataUsedW,
  output logic               DataRead,
  tlp_tx_scheduler_if.master tx,
  output logic               BufferDone,
  output logic [15:0]        BufferDoneIndex,
  output logic               Busy
);

  localparam logic [31:0] BYTES_PER_TLP = 32'(WORDS_PER_TLP * 8);
  localparam logic [9:0]  TLP_LEN_DW    = 10'(2 * WORDS_PER_TLP);
  localparam logic [9:0]  START_LEVEL   = 10'(WORDS_PER_TLP);
  localparam logic [5:0]  LAST_WORD     = 6'(WORDS_PER_TLP - 1);
  localparam logic [31:0] DW0           = {3'b010, 5'b00000, 8'h00, 6'h00, TLP_LEN_DW};
  localparam logic [31:0] DW1           = {REQUESTER_ID, 8'h00, 8'hFF};

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    PAYLOAD,
    LAST
  } SchedState;

  SchedState   state;
  logic [15:0] bufCounter;
  logic        lastOfBuffer;
  logic [29:0] tlpAddr;
  logic [31:0] hold;
  logic [5:0]  wordCount;
  logic [15:0] doneIndexReg;
  logic        headerReadReg;

  logic        startNow;
  logic        accept;
  logic [31:0] nextAddr;
  logic        unusedBits;

  assign startNow = (state == IDLE) && Enable && !HeaderEmpty && (DataUsedW >= START_LEVEL);
  assign nextAddr = (HeaderQ[24] ? BufferBase1 : BufferBase0) + (32'(HeaderQ[23:8]) * BYTES_PER_TLP);
  assign accept   = tx.TxValid && tx.TxReady;

  // Flags travel with the header but do not affect the TLP; the address is qword aligned.
  assign unusedBits = &{1'b0, HeaderQ[7:0], nextAddr[1:0]};

  // Everything about a TLP (address, buffer id, end-of-buffer) is captured at start,
  // so config inputs may change freely while the TLP is on the wire.
  always_ff @(posedge Clock or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      bufCounter    <= '0;
      lastOfBuffer  <= 1'b0;
      tlpAddr       <= '0;
      hold          <= '0;
      wordCount     <= '0;
      doneIndexReg  <= '0;
      headerReadReg <= 1'b0;
    end else begin
      headerReadReg <= 1'b0;
      case (state)
        IDLE: begin
          if (startNow) begin
            bufCounter    <= HeaderQ[39:24];
            lastOfBuffer  <= (HeaderQ[23:8] == BufferLengthTLPs);
            tlpAddr       <= nextAddr[31:2];
            headerReadReg <= 1'b1;
            state         <= HDR0;
          end
        end
        HDR0: begin
          if (tx.TxReady) state <= HDR1;
        end
        HDR1: begin
          if (tx.TxReady) begin
            hold      <= DataQ[31:0];
            wordCount <= 6'd1;
            state     <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (tx.TxReady) begin
            hold <= DataQ[31:0];
            if (wordCount == LAST_WORD) state <= LAST;
            else wordCount <= wordCount + 6'd1;
          end
        end
        LAST: begin
          if (tx.TxReady) begin
            if (lastOfBuffer) doneIndexReg <= bufCounter;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Each qword straddles two beats: its upper DW goes out live from the show-ahead
  // head, its lower DW waits in the holding register for the next beat.
  always_comb begin
    tx.TxData = 64'h0;
    tx.TxSOF  = 1'b0;
    tx.TxEOF  = 1'b0;
    tx.TxRem  = 1'b0;
    case (state)
      HDR0: begin
        tx.TxData = {DW0, DW1};
        tx.TxSOF  = 1'b1;
      end
      HDR1:    tx.TxData = {tlpAddr, 2'b00, DataQ[63:32]};
      PAYLOAD: tx.TxData = {hold, DataQ[63:32]};
      LAST: begin
        tx.TxData = {hold, 32'h0};
        tx.TxEOF  = 1'b1;
        tx.TxRem  = 1'b1;
      end
      default: tx.TxData = 64'h0;
    endcase
  end

  assign tx.TxValid      = (state != IDLE);
  assign Busy            = (state != IDLE);
  assign HeaderRead      = headerReadReg;
  assign DataRead        = accept && ((state == HDR1) || (state == PAYLOAD));
  assign BufferDone      = accept && (state == LAST) && lastOfBuffer;
  assign BufferDoneIndex = BufferDone ? bufCounter : doneIndexReg;

endmodule

// File: tb/tb_tlp_tx_scheduler.sv
// Directed bench for tlp_tx_scheduler: a vector table of single TLPs plus
// hand-written threshold, enable, and mid-TLP reset sequences.
module tb_tlp_tx_scheduler;
  localparam int          W        = 16;
  localparam logic [63:0] HDR_BEAT = 64'h4000_0020_0100_00FF;

  typedef struct {
    logic [15:0] bufCnt;
    logic [15:0] tlpCnt;
    logic [31:0] base0;
    logic [31:0] base1;
    logic [15:0] bufLen;
    bit          randReady;
    logic [31:0] expAddr;
    int          expDone;
    logic [15:0] expIdx;
  } TlpVector;

  logic        Clock = 1'b0;
  logic        rst_n;
  logic        Enable;
  logic [31:0] BufferBase0;
  logic [31:0] BufferBase1;
  logic [15:0] BufferLengthTLPs;
  logic        HeaderEmpty;
  logic [39:0] HeaderQ;
  logic        HeaderRead;
  logic [63:0] DataQ;
  logic [9:0]  DataUsedW;
  logic        DataRead;
  logic        BufferDone;
  logic [15:0] BufferDoneIndex;
  logic        Busy;

  tlp_tx_scheduler_if txBus();

  tlp_tx_scheduler #(.WORDS_PER_TLP(W), .REQUESTER_ID(16'h0100)) dut (
    .Clock(Clock),
    .rst_n(rst_n),
    .Enable(Enable),
    .BufferBase0(BufferBase0),
    .BufferBase1(BufferBase1),
    .BufferLengthTLPs(BufferLengthTLPs),
    .HeaderEmpty(HeaderEmpty),
    .HeaderQ(HeaderQ),
    .HeaderRead(HeaderRead),
    .DataQ(DataQ),
    .DataUsedW(DataUsedW),
    .DataRead(DataRead),
    .tx(txBus),
    .BufferDone(BufferDone),
    .BufferDoneIndex(BufferDoneIndex),
    .Busy(Busy)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad = 0;

  logic [39:0] hdrFifo[$];
  logic [63:0] dataFifo[$];
  logic [63:0] beatData[$];
  bit          beatSof[$];
  bit          beatEof[$];
  bit          beatRem[$];
  int          nData, nHdr, nDone, nValid, nBusy, nRdViol;
  logic [15:0] doneIdxSeen;
  bit          eofDone;
  bit          stalledPrev;
  logic [63:0] stallData;
  logic [63:0] curWords[W];
  TlpVector    vecs[7];

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] mkWord(input int v, input int i);
    if (v == 0) return 64'(i);
    return {16'hD000 + 16'(v), 16'(i), 16'hE000 + 16'(v), 16'h0100 + 16'(i)};
  endfunction

  task automatic refreshFifos();
    HeaderEmpty = (hdrFifo.size() == 0);
    HeaderQ     = HeaderEmpty ? 40'h0 : hdrFifo[0];
    DataQ       = (dataFifo.size() == 0) ? 64'h0 : dataFifo[0];
    DataUsedW   = 10'(dataFifo.size());
  endtask

  task automatic pushHeader(input logic [15:0] bufCnt, input logic [15:0] tlpCnt, input logic [7:0] flags);
    hdrFifo.push_back({bufCnt, tlpCnt, flags});
    refreshFifos();
  endtask

  task automatic fillWords(input int v);
    for (int i = 0; i < W; i++) curWords[i] = mkWord(v, i);
  endtask

  task automatic pushData(input int first, input int stop);
    for (int i = first; i < stop; i++) dataFifo.push_back(curWords[i]);
    refreshFifos();
  endtask

  task automatic clearCapture();
    beatData.delete();
    beatSof.delete();
    beatEof.delete();
    beatRem.delete();
    nData = 0; nHdr = 0; nDone = 0; nValid = 0; nBusy = 0; nRdViol = 0;
    doneIdxSeen = 16'h0;
    eofDone = 1'b0;
    stalledPrev = 1'b0;
  endtask

  // One clock: drive TxReady at the falling edge, observe just after, then pop
  // the FIFO models for whatever the DUT read at the rising edge.
  task automatic doCycle(input bit ready);
    bit popData, popHdr, acc;
    txBus.TxReady = ready;
    #1;
    acc     = txBus.TxValid && txBus.TxReady;
    popData = DataRead;
    popHdr  = HeaderRead;
    if (stalledPrev && txBus.TxValid) checkOutput("stall_hold", txBus.TxData, stallData);
    stalledPrev = txBus.TxValid && !txBus.TxReady;
    stallData   = txBus.TxData;
    if (txBus.TxValid) nValid++;
    if (Busy) nBusy++;
    if (DataRead && !acc) nRdViol++;
    if (DataRead) nData++;
    if (HeaderRead) nHdr++;
    if (BufferDone) begin
      nDone++;
      doneIdxSeen = BufferDoneIndex;
    end
    if (acc) begin
      beatData.push_back(txBus.TxData);
      beatSof.push_back(txBus.TxSOF);
      beatEof.push_back(txBus.TxEOF);
      beatRem.push_back(txBus.TxRem);
      if (txBus.TxEOF) eofDone = 1'b1;
    end
    @(posedge Clock);
    #1;
    if (popData && dataFifo.size() > 0) void'(dataFifo.pop_front());
    if (popHdr && hdrFifo.size() > 0) void'(hdrFifo.pop_front());
    refreshFifos();
    @(negedge Clock);
  endtask

  task automatic runTlp(input bit randReady, input bit scramble, input bit dropEnable);
    clearCapture();
    for (int c = 0; c < 400 && !eofDone; c++) begin
      doCycle(randReady ? bit'($urandom_range(0, 1)) : 1'b1);
      if (scramble && nHdr > 0) begin
        BufferBase0      = 32'hDEAD_BEE0;
        BufferBase1      = 32'hCAFE_F000;
        BufferLengthTLPs = 16'h7777;
      end
      if (dropEnable && beatData.size() >= 2) Enable = 1'b0;
    end
    checkOutput("tlp_complete", 64'(eofDone), 64'h1);
  endtask

  task automatic checkTlp(input logic [31:0] expAddr, input int expDone, input logic [15:0] expIdx);
    logic [63:0] expBeats[W+2];
    int sofCnt, eofCnt, remCnt, last;
    expBeats[0] = HDR_BEAT;
    expBeats[1] = {expAddr, curWords[0][63:32]};
    for (int j = 2; j <= W; j++) expBeats[j] = {curWords[j-2][31:0], curWords[j-1][63:32]};
    expBeats[W+1] = {curWords[W-1][31:0], 32'h0};
    checkOutput("beat_count", 64'(beatData.size()), 64'(W + 2));
    for (int j = 0; j < W + 2; j++)
      if (j < beatData.size()) checkOutput($sformatf("beat%0d", j), beatData[j], expBeats[j]);
    sofCnt = 0; eofCnt = 0; remCnt = 0;
    foreach (beatData[j]) begin
      sofCnt += int'(beatSof[j]);
      eofCnt += int'(beatEof[j]);
      remCnt += int'(beatRem[j]);
    end
    last = beatData.size() - 1;
    checkOutput("sof_count", 64'(sofCnt), 64'h1);
    checkOutput("eof_count", 64'(eofCnt), 64'h1);
    checkOutput("rem_count", 64'(remCnt), 64'h1);
    if (last >= 0) begin
      checkOutput("sof_first", 64'(beatSof[0]), 64'h1);
      checkOutput("eof_rem_last", 64'({beatEof[last], beatRem[last]}), 64'h3);
    end
    checkOutput("data_reads", 64'(nData), 64'(W));
    checkOutput("header_reads", 64'(nHdr), 64'h1);
    checkOutput("read_outside_accept", 64'(nRdViol), 64'h0);
    checkOutput("buffer_done_pulses", 64'(nDone), 64'(expDone));
    if (expDone > 0) checkOutput("done_index_pulse", 64'(doneIdxSeen), 64'(expIdx));
    checkOutput("done_index_held", 64'(BufferDoneIndex), 64'(expIdx));
  endtask

  task automatic applyStimulus(input TlpVector tv, input int v);
    BufferBase0      = tv.base0;
    BufferBase1      = tv.base1;
    BufferLengthTLPs = tv.bufLen;
    Enable           = 1'b1;
    fillWords(v);
    pushHeader(tv.bufCnt, tv.tlpCnt, 8'h1F);
    pushData(0, W);
    runTlp(tv.randReady, tv.randReady, 1'b0);
    checkTlp(tv.expAddr, tv.expDone, tv.expIdx);
  endtask

  initial begin
    vecs[0] = '{16'd0, 16'd3,      32'h1000_0000, 32'h2000_0000, 16'd5,      1'b0, 32'h1000_0180, 0, 16'd0};
    vecs[1] = '{16'd1, 16'd0,      32'h1000_0000, 32'h2000_0000, 16'd5,      1'b0, 32'h2000_0000, 0, 16'd0};
    vecs[2] = '{16'd0, 16'd0,      32'h1000_0000, 32'h2000_0000, 16'd2,      1'b0, 32'h1000_0000, 0, 16'd0};
    vecs[3] = '{16'd0, 16'd1,      32'h1000_0000, 32'h2000_0000, 16'd2,      1'b0, 32'h1000_0080, 0, 16'd0};
    vecs[4] = '{16'd0, 16'd2,      32'h1000_0000, 32'h2000_0000, 16'd2,      1'b0, 32'h1000_0100, 1, 16'd0};
    vecs[5] = '{16'd3, 16'd1,      32'h1000_0000, 32'h3000_0008, 16'd1,      1'b1, 32'h3000_0088, 1, 16'd3};
    vecs[6] = '{16'd0, 16'hFFFF,   32'hFFFF_0000, 32'h2000_0000, 16'hFFFF,   1'b1, 32'h007E_FF80, 1, 16'd0};

    rst_n            = 1'b0;
    Enable           = 1'b1;
    BufferBase0      = 32'h1000_0000;
    BufferBase1      = 32'h2000_0000;
    BufferLengthTLPs = 16'd0;
    txBus.TxReady    = 1'b1;
    fillWords(1);
    pushHeader(16'd0, 16'd0, 8'h00);
    pushData(0, W);
    repeat (2) @(negedge Clock);
    #1;
    checkOutput("reset_txvalid", 64'(txBus.TxValid), 64'h0);
    checkOutput("reset_txdata", txBus.TxData, 64'h0);
    checkOutput("reset_framing", 64'({txBus.TxSOF, txBus.TxEOF, txBus.TxRem}), 64'h0);
    checkOutput("reset_reads", 64'({HeaderRead, DataRead}), 64'h0);
    checkOutput("reset_done", 64'({BufferDone, BufferDoneIndex}), 64'h0);
    checkOutput("reset_busy", 64'(Busy), 64'h0);
    hdrFifo.delete();
    dataFifo.delete();
    refreshFifos();
    @(negedge Clock);
    rst_n = 1'b1;

    for (int v = 0; v < 7; v++) applyStimulus(vecs[v], v);

    // Data level one short of a full TLP must hold off the start.
    BufferBase0      = 32'h1000_0000;
    BufferLengthTLPs = 16'd9;
    Enable           = 1'b1;
    fillWords(8);
    pushHeader(16'd0, 16'd2, 8'h00);
    pushData(0, W - 1);
    clearCapture();
    repeat (6) doCycle(1'b1);
    checkOutput("below_level_valid", 64'(nValid), 64'h0);
    checkOutput("below_level_hdr_read", 64'(nHdr), 64'h0);
    pushData(W - 1, W);
    runTlp(1'b0, 1'b0, 1'b0);
    checkTlp(32'h1000_0100, 0, 16'd0);

    // Dropping Enable mid-TLP finishes that TLP and then parks in IDLE.
    fillWords(9);
    pushHeader(16'd0, 16'd4, 8'h00);
    pushHeader(16'd0, 16'd5, 8'h00);
    pushData(0, W);
    pushData(0, W);
    runTlp(1'b0, 1'b0, 1'b1);
    checkTlp(32'h1000_0200, 0, 16'd0);
    clearCapture();
    repeat (8) doCycle(1'b1);
    checkOutput("disabled_valid", 64'(nValid), 64'h0);
    checkOutput("disabled_busy", 64'(nBusy), 64'h0);
    Enable = 1'b1;
    runTlp(1'b0, 1'b0, 1'b0);
    checkTlp(32'h1000_0280, 0, 16'd0);

    // Reset in the middle of the payload abandons the TLP immediately.
    fillWords(10);
    pushHeader(16'd1, 16'd0, 8'h00);
    pushData(0, W);
    clearCapture();
    for (int c = 0; c < 50 && beatData.size() < 5; c++) doCycle(1'b1);
    checkOutput("reached_payload", 64'(beatData.size()), 64'h5);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_txvalid", 64'(txBus.TxValid), 64'h0);
    checkOutput("midrst_busy", 64'(Busy), 64'h0);
    checkOutput("midrst_txdata", txBus.TxData, 64'h0);
    checkOutput("midrst_ctrl", 64'({txBus.TxSOF, txBus.TxEOF, txBus.TxRem, HeaderRead, DataRead, BufferDone}), 64'h0);
    hdrFifo.delete();
    dataFifo.delete();
    refreshFifos();
    @(negedge Clock);
    rst_n = 1'b1;
    BufferBase0      = 32'h1000_0000;
    BufferLengthTLPs = 16'd0;
    fillWords(11);
    pushHeader(16'd0, 16'd0, 8'h00);
    pushData(0, W);
    runTlp(1'b0, 1'b0, 1'b0);
    checkTlp(32'h1000_0000, 1, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tlp_tx_scheduler.md
Name: tlp_tx_scheduler

Overview:
- Drains the acquisition path's header FIFO (40-bit) and data FIFO (64-bit) and emits PCIe posted Memory-Write TLPs to the PCIe core's 64-bit transmit interface.
- Each TLP carries WORDS_PER_TLP data qwords. The address is computed from ping-pong DMA buffer bases and the buffer/TLP indices carried in the header word.
- Sits between the ADC packer FIFOs and the PCIe endpoint TX port, and signals buffer completion to the host interrupt logic.

Parameters:
- WORDS_PER_TLP, 16: payload qwords per TLP. Power of two, 2..32.
- REQUESTER_ID, 16'h0100: value placed in TLP DW1[31:16].

Ports:
- Clock, in, 1: single clock for all logic.
- rst_n, in, 1: asynchronous active-low reset.
- Enable, in, 1: permits starting new TLPs.
- BufferBase0, in, 32: byte address of buffer 0. Qword aligned.
- BufferBase1, in, 32: byte address of buffer 1.
- BufferLengthTLPs, in, 16: last TLP index in a buffer (buffer holds N+1 TLPs).
- HeaderEmpty, in, 1: header FIFO empty.
- HeaderQ, in, 40: show-ahead head word {BufferCounter[15:0], TLPCounter[15:0], Flags[7:0]}.
- HeaderRead, out, 1: pops header FIFO.
- DataQ, in, 64: show-ahead data head word.
- DataUsedW, in, 10: data FIFO fill level.
- DataRead, out, 1: pops data FIFO.
- TxData, out, 64: TLP beat; DW order is [63:32] first.
- TxSOF, out, 1: first beat.
- TxEOF, out, 1: last beat.
- TxRem, out, 1: on EOF, 1 means only [63:32] is valid.
- TxValid, out, 1: beat valid.
- TxReady, in, 1: core accepts the beat when TxValid && TxReady.
- BufferDone, out, 1: one-cycle pulse.
- BufferDoneIndex, out, 16: BufferCounter of the completed buffer.
- Busy, out, 1: high when not in IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, holding register 0.
- Start condition in IDLE: Enable && !HeaderEmpty && DataUsedW >= WORDS_PER_TLP. On start, latch HeaderQ, pulse HeaderRead for one cycle, go to HDR0.
- Address: Base = latched BufferCounter[0] ? BufferBase1 : BufferBase0. Addr = Base + TLPCounter*(WORDS_PER_TLP*8), 32-bit modulo. Addr is registered in the start cycle.
- DW0 = {3'b010, 5'b00000, 8'h00, 6'h00, LEN[9:0]}, where LEN = 2*WORDS_PER_TLP.
- DW1 = {REQUESTER_ID, tag 8'h00, 8'hFF}. DW2 = {Addr[31:2], 2'b00}.
- HDR0: drive {DW0, DW1} with TxSOF=1. Advance on accept.
- HDR1: drive {DW2, DataQ[63:32]}. On accept, DataRead=1, DataQ[31:0] goes to the holding register, go to PAYLOAD. Payload count k=1.
- PAYLOAD: drive {hold, DataQ[63:32]}. On accept, DataRead=1, refresh hold, k++. After word WORDS_PER_TLP-1 is consumed, go to LAST.
- LAST: drive {hold, 32'h0} with TxEOF=1 and TxRem=1. On accept, go to IDLE.
- Total is WORDS_PER_TLP+2 beats per TLP, with exactly WORDS_PER_TLP DataRead pulses and 1 HeaderRead pulse.
- Backpressure: TxValid stays 1 and TxData is held stable while TxReady=0. DataRead is only ever asserted in an accept cycle.
- Data availability is guaranteed by the start check, so there is no data underrun mid-TLP.
- Enable deassert mid-TLP: the current TLP completes, then the block stays in IDLE.
- Back-to-back: IDLE lasts at least one cycle between TLPs.
- BufferDone: pulses in the LAST accept cycle when latched TLPCounter == BufferLengthTLPs. BufferDoneIndex = latched BufferCounter, held until the next pulse.
- Config inputs are sampled only at start; changes mid-TLP have no effect on the current TLP.
- Async reset mid-TLP: immediate return to IDLE with outputs 0. The partial TLP is abandoned and no FIFO flush is performed.
- Busy = (state != IDLE).

Test Plan:
- Single TLP, WORDS_PER_TLP=16, Base0=0x1000_0000, header {16'd0, 16'd3, 8'h1F}, data qwords 0..15, TxReady=1 -> 18 beats. Beat0 = {0x4000_0020, 0x0100_00FF}; beat1 = {0x1000_0180, 0x0000_0000}; EOF with TxRem=1. 16 DataRead pulses, 1 HeaderRead pulse.
- Ping-pong: header BufferCounter=1, TLPCounter=0, Base1=0x2000_0000 -> DW2 = 0x2000_0000.
- BufferLengthTLPs=2, headers with TLPCounter 0,1,2 -> BufferDone pulses once, on the third TLP's EOF accept, with BufferDoneIndex=0.
- DataUsedW=15, header present -> no TxValid. Raising DataUsedW to 16 -> TLP starts.
- TxReady toggled randomly at 50% -> TxData stable while stalled, payload byte-exact, DataRead count = 16.
- rst_n asserted during PAYLOAD -> all outputs 0 immediately. After release, the next TLP is well-formed from HDR0.
